// File: rtl/chinx_arb4.sv
// chinx_arb4: four-requester round-robin arbiter driving a shared mux select,
// holding each grant until done with a watchdog that revokes stuck grants.
module chinx_arb4 #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] req_i,
   input  logic       done_i,
   output logic [3:0] gnt_o,
   output logic [1:0] sel_o,
   output logic       busy_o,
   output logic       timeout_o
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [1:0]           r_ptr;
   logic [1:0]           r_sel;
   logic [3:0]           r_gnt;
   logic                 r_busy;
   logic                 r_to;
   logic                 w_grant;
   logic                 w_abort;
   logic                 w_to;
   logic                 w_rel;
   logic                 w_to_rel;
   logic [3:0]           w_req;
   logic [2:0]           w_pick;

   // Search ptr+1, ptr+2, ptr+3, ptr; the last hit in this descending loop is the nearest one.
   function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [2:0] res;
      res = '0;
      for (int k = 4; k >= 1; k--)
         if (req[ptr + 2'(k)]) res = {1'b1, ptr + 2'(k)};
      return res;
   endfunction

   assign w_grant  = r_state == GRANT;
   assign w_abort  = !req_i[r_sel];
   assign w_to     = TIMEOUT_CYCLES != 0 && r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   assign w_rel    = w_grant && (done_i || w_abort || w_to);
   assign w_to_rel = w_grant && !done_i && !w_abort && w_to;
   // A revoked owner sits out the re-arbitration it caused.
   assign w_req    = w_to_rel ? req_i & ~(4'b0001 << r_sel) : req_i;
   assign w_pick   = pick(w_req, r_ptr);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= 2'd3;
         r_sel   <= 2'd0;
         r_gnt   <= 4'b0000;
         r_busy  <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_to <= w_to_rel;
         if (!w_grant || w_rel) begin
            if (w_pick[2]) begin
               r_state <= GRANT;
               r_gnt   <= 4'b0001 << w_pick[1:0];
               r_sel   <= w_pick[1:0];
               r_ptr   <= w_pick[1:0];
               r_busy  <= 1'b1;
               r_cnt   <= '0;
            end else begin
               r_state <= IDLE;
               r_gnt   <= 4'b0000;
               r_busy  <= 1'b0;
            end
         end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign gnt_o     = r_gnt;
   assign sel_o     = r_sel;
   assign busy_o    = r_busy;
   assign timeout_o = r_to;
endmodule

// File: tb/tb_chinx_arb4.sv
// tb_chinx_arb4: two arbiters (watchdog 255 and 4) on shared stimulus, each checked
// every cycle against a behavioural owner/pointer model plus literal expectations.
module tb_chinx_arb4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [3:0] gnt [2];
   logic [1:0] sel [2];
   logic       busy [2];
   logic       tmo [2];
   int         checks = 0;
   int         errors = 0;
   int         lim [2] = '{255, 4};
   int         m_own [2];
   int         m_ptr [2];
   int         m_sel [2];
   int         m_hold [2];
   bit         m_to [2];

   always #5 clk = ~clk;

   chinx_arb4 #(.TIMEOUT_CYCLES(255), .CNT_WIDTH(8)) u_a (
      .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
      .gnt_o(gnt[0]), .sel_o(sel[0]), .busy_o(busy[0]), .timeout_o(tmo[0]));
   chinx_arb4 #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) u_b (
      .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
      .gnt_o(gnt[1]), .sel_o(sel[1]), .busy_o(busy[1]), .timeout_o(tmo[1]));

   // Owner is -1 when idle; hold counts completed grant cycles.
   task automatic step(input int i);
      logic [3:0] r;
      int         w;
      bit         rel, msk;
      if (rst) begin
         m_own[i] = -1; m_sel[i] = 0; m_ptr[i] = 3; m_hold[i] = 0; m_to[i] = 0;
      end else begin
         m_to[i] = 0; rel = 0; msk = 0; r = req;
         if (m_own[i] < 0) rel = 1;
         else if (done || !req[m_own[i]]) rel = 1;
         else if (lim[i] != 0 && m_hold[i] == lim[i] - 1) begin
            rel = 1; msk = 1; m_to[i] = 1;
         end
         if (rel) begin
            if (msk) r[m_own[i]] = 1'b0;
            w = -1;
            for (int o = 1; o <= 4; o++)
               if (w < 0 && r[(m_ptr[i] + o) % 4]) w = (m_ptr[i] + o) % 4;
            if (w >= 0) begin
               m_own[i] = w; m_sel[i] = w; m_ptr[i] = w; m_hold[i] = 0;
            end else m_own[i] = -1;
         end else m_hold[i]++;
      end
   endtask

   task automatic chk(input string n, input int i, input logic [3:0] a, input logic [3:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s dut%0d got %h want %h", n, i, a, e);
      end
   endtask

   task automatic compare();
      for (int i = 0; i < 2; i++) begin
         chk("gnt", i, gnt[i], m_own[i] < 0 ? 4'b0000 : 4'(1 << m_own[i]));
         chk("sel", i, {2'b00, sel[i]}, 4'(m_sel[i]));
         chk("busy", i, {3'b000, busy[i]}, {3'b000, m_own[i] >= 0});
         chk("timeout", i, {3'b000, tmo[i]}, {3'b000, m_to[i]});
      end
   endtask

   task automatic lit(input int i, input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
      chk("lit_gnt", i, gnt[i], g);
      chk("lit_sel", i, {2'b00, sel[i]}, {2'b00, s});
      chk("lit_busy", i, {3'b000, busy[i]}, {3'b000, b});
      chk("lit_timeout", i, {3'b000, tmo[i]}, {3'b000, t});
   endtask

   task automatic cyc(input logic [3:0] r, input logic d, input logic rs);
      req = r; done = d; rst = rs;
      @(posedge clk);
      step(0);
      step(1);
      @(negedge clk);
      compare();
   endtask

   initial begin
      logic [3:0] rr;
      cyc(4'h0, 0, 1);
      lit(0, 4'b0000, 2'd0, 0, 0);
      cyc(4'b0110, 0, 0);
      lit(0, 4'b0010, 2'd1, 1, 0);
      cyc(4'b0110, 1, 0);
      lit(0, 4'b0100, 2'd2, 1, 0);
      cyc(4'b0000, 1, 0);
      lit(0, 4'b0000, 2'd2, 0, 0);
      // Fairness with everyone requesting
      cyc(4'h0, 0, 1);
      cyc(4'hF, 0, 0);
      for (int g = 0; g < 6; g++) begin
         lit(0, 4'(1 << (g % 4)), 2'(g % 4), 1, 0);
         cyc(4'hF, 0, 0);
         cyc(4'hF, 0, 0);
         cyc(4'hF, 1, 0);
      end
      cyc(4'b1000, 0, 0);
      lit(0, 4'b1000, 2'd3, 1, 0);
      cyc(4'b1000, 1, 0);
      lit(0, 4'b1000, 2'd3, 1, 0);
      cyc(4'b1000, 1, 0);
      lit(0, 4'b1000, 2'd3, 1, 0);
      // Watchdog on the short-timeout instance
      cyc(4'h0, 0, 1);
      cyc(4'b0101, 0, 0);
      lit(1, 4'b0001, 2'd0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0101, 0, 0);
         lit(1, 4'b0001, 2'd0, 1, 0);
      end
      cyc(4'b0101, 0, 0);
      lit(1, 4'b0100, 2'd2, 1, 1);
      lit(0, 4'b0001, 2'd0, 1, 0);
      cyc(4'b0101, 0, 0);
      lit(1, 4'b0100, 2'd2, 1, 0);
      cyc(4'h0, 0, 1);
      cyc(4'b0001, 0, 0);
      lit(1, 4'b0001, 2'd0, 1, 0);
      for (int k = 0; k < 3; k++) cyc(4'b0001, 0, 0);
      cyc(4'b0001, 0, 0);
      lit(1, 4'b0000, 2'd0, 0, 1);
      cyc(4'b0001, 0, 0);
      lit(1, 4'b0001, 2'd0, 1, 0);
      // Abort hands over without a timeout pulse
      cyc(4'h0, 0, 1);
      cyc(4'b0100, 0, 0);
      lit(0, 4'b0100, 2'd2, 1, 0);
      cyc(4'b0001, 0, 0);
      lit(0, 4'b0001, 2'd0, 1, 0);
      // Reset mid-grant
      cyc(4'h0, 0, 1);
      cyc(4'b0010, 0, 0);
      lit(0, 4'b0010, 2'd1, 1, 0);
      cyc(4'b0010, 0, 0);
      cyc(4'b0010, 0, 0);
      cyc(4'b0010, 1, 1);
      lit(0, 4'b0000, 2'd0, 0, 0);
      lit(1, 4'b0000, 2'd0, 0, 0);
      cyc(4'hF, 0, 0);
      lit(0, 4'b0001, 2'd0, 1, 0);
      // Long holds push the 255-cycle watchdog
      for (int n = 0; n < 600; n++) cyc(4'hF, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         rr = req;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(7) == 0) rr[b] = ~rr[b];
         cyc(rr, $urandom_range(7) == 0, $urandom_range(199) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/chinx_arb4.md
Name: chinx_arb4

Overview:
- Four-requester round-robin arbiter that owns the select of a shared 4:1 datapath mux, e.g. a shared memory or bus port used by IF, MEM, DMA and debug masters.
- Grants one requester at a time and holds the grant until that requester signals completion.
- Drives the mux select and a one-hot grant.
- A watchdog forcibly releases a grant held too long.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles a grant may be held without done_i; 0 disables the watchdog.
- CNT_WIDTH, 8, width of the hold counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  4  request per master; bit n = master n.
- done_i  input  1  current owner's transfer completes this cycle.
- gnt_o  output  4  one-hot grant, registered; all-zero when idle.
- sel_o  output  2  registered mux select = index of current/last owner.
- busy_o  output  1  high while any grant is active.
- timeout_o  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Interface fixed: one clock (clk_i); reset rst_i is synchronous and active-high.

Reset values:
- gnt_o=0, sel_o=0, busy_o=0, timeout_o=0.
- Priority pointer ptr=3, so master 0 has highest priority first.
- Hold counter = 0; state IDLE.

States:
- IDLE:
  - If req_i==0, stay IDLE; outputs hold, sel_o keeps last owner.
  - Otherwise pick the winner by searching ptr+1, ptr+2, ptr+3, ptr (mod 4) for the first set bit.
  - Next cycle: gnt_o=onehot(winner), sel_o=winner, busy_o=1, ptr=winner, counter=0, state GRANT.
  - Latency: req_i sampled high at edge N produces gnt_o at edge N+1.
- GRANT:
  - Counter increments each cycle, saturating at its maximum.
  - Release conditions, in priority order:
    1. done_i=1
    2. req_i[owner]=0 (abort)
    3. TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1
  - On release, re-arbitrate in the same cycle over req_i with ptr=owner.
  - The owner's own bit is eligible but has lowest priority. On release by abort or timeout, the owner's bit is masked out for this arbitration.
  - If a winner exists: back-to-back grant next cycle, with no idle bubble; gnt_o switches directly, counter=0, stay GRANT.
  - If no winner: gnt_o=0, busy_o=0, state IDLE; sel_o retains the old owner.
  - Timeout release also drives timeout_o=1 for exactly that next cycle.
  - Otherwise the grant, sel_o and ptr are held.

Invariants:
- gnt_o is always zero or one-hot.
- gnt_o != 0 exactly when busy_o=1.
- When busy_o=1, sel_o equals the index of the set bit in gnt_o.

Boundary conditions:
- done_i asserted while IDLE is ignored.
- Requests changing in the same cycle as done_i: the arbitration uses the req_i value present in that cycle.
- rst_i high in any state (including mid-GRANT) wins over all other inputs. Next cycle: all reset values, with no timeout pulse.
- The counter never wraps; it saturates.

Test Plan:
- Reset, then req_i=4'b0110 from cycle 0 -> gnt_o=4'b0010 and sel_o=1 at edge 1. Pulse done_i -> next cycle gnt_o=4'b0100 and sel_o=2 with no idle gap. Drop requests, then done_i -> gnt_o=0, busy_o=0, sel_o stays 2.
- Fairness: hold req_i=4'b1111, and pulse done_i every 3rd cycle of each grant -> grant order 0,1,2,3,0,1; each master receives exactly one grant per 4 releases.
- Single requester: req_i=4'b1000 held, done_i pulsed twice -> master 3 re-granted back-to-back with no gap, and gnt_o stays 4'b1000 continuously.
- Watchdog with TIMEOUT_CYCLES=4: req_i=4'b0001 and req_i=4'b0100, no done_i -> master 0 granted for 4 cycles, then timeout_o pulses one cycle and gnt_o=4'b0100. Rerun with only req_i=4'b0001 -> release to IDLE with timeout_o pulse, then re-grant master 0 the following cycle.
- Abort: grant master 2, deassert req_i[2] while req_i[0]=1 -> next cycle gnt_o=4'b0001, no timeout_o.
- Reset mid-grant: owner=1 at counter=2, assert rst_i -> next cycle gnt_o=0, sel_o=0, busy_o=0. With req_i=4'b1111 after reset, master 0 wins first.
